// File: rtl/sram_byte_ctrl_if.sv
// Request/response bundle for sram_byte_ctrl: valid/ready request port plus
// registered response pulse and the post-reset clear status.
interface sram_byte_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  localparam int BYTES = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [BYTES-1:0]  req_be;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              init_done;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, init_done
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, init_done
  );
endinterface

// File: rtl/sram_byte_ctrl.sv
// Byte-addressable SRAM with per-lane write enables; misaligned accesses take
// two row cycles, and an optional sweep zeroes every row after reset.
module sram_byte_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  sram_byte_ctrl_if.slave  bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam int OFF_W = (SHIFT > 0) ? SHIFT : 1;
  localparam int ROW_W = ADDR_W - SHIFT;
  localparam int DEPTH = 2 ** ROW_W;
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_SPLIT = 2'd2;

  // Physical byte j of a row carries request lane (j - off) mod BYTES.
  function automatic logic [DATA_W-1:0] lane_to_phys(input logic [DATA_W-1:0] d,
                                                     input logic [OFF_W-1:0]  off);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int j = 0; j < BYTES; j++) begin
      int lane;
      lane = (j - int'(off) + BYTES) % BYTES;
      r[8*j +: 8] = d[8*lane +: 8];
    end
    return r;
  endfunction

  // First row owns physical bytes off..BYTES-1, the second row bytes 0..off-1.
  function automatic logic [BYTES-1:0] phys_be(input logic [BYTES-1:0] be,
                                               input logic [OFF_W-1:0] off,
                                               input logic             first);
    logic [BYTES-1:0] r;
    r = '0;
    for (int j = 0; j < BYTES; j++) begin
      int lane;
      lane = (j - int'(off) + BYTES) % BYTES;
      r[j] = be[lane] && ((j >= int'(off)) == first);
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] phys_to_lane(input logic [DATA_W-1:0] lo,
                                                     input logic [DATA_W-1:0] hi,
                                                     input logic [OFF_W-1:0]  off);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < BYTES; k++) begin
      int j;
      j = (k + int'(off)) % BYTES;
      r[8*k +: 8] = (k + int'(off) < BYTES) ? lo[8*j +: 8] : hi[8*j +: 8];
    end
    return r;
  endfunction

  logic [1:0]        state_q,     state_d;
  logic [ROW_W-1:0]  clr_row_q,   clr_row_d;
  logic              init_done_q, init_done_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [DATA_W-1:0] hold_q,      hold_d;
  logic [ROW_W-1:0]  sp_row_q,    sp_row_d;
  logic [OFF_W-1:0]  sp_off_q,    sp_off_d;
  logic              sp_we_q,     sp_we_d;
  logic [BYTES-1:0]  sp_be_q,     sp_be_d;
  logic [DATA_W-1:0] sp_wdata_q,  sp_wdata_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ROW_W-1:0]  mem_row;
  logic [BYTES-1:0]  mem_be;
  logic [DATA_W-1:0] mem_wdata;

  logic [ROW_W-1:0]  req_row;
  logic [OFF_W-1:0]  req_off;

  assign req_row = ROW_W'(bus.req_addr >> SHIFT);
  assign req_off = OFF_W'(bus.req_addr & ADDR_W'(BYTES - 1));

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    clr_row_d   = clr_row_q;
    init_done_d = init_done_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    hold_d      = hold_q;
    sp_row_d    = sp_row_q;
    sp_off_d    = sp_off_q;
    sp_we_d     = sp_we_q;
    sp_be_d     = sp_be_q;
    sp_wdata_d  = sp_wdata_q;
    mem_row     = '0;
    mem_be      = '0;
    mem_wdata   = '0;

    case (state_q)
      ST_INIT: begin
        if (INIT_CLEAR) begin
          mem_row   = clr_row_q;
          mem_be    = '1;
          clr_row_d = clr_row_q + ROW_ONE;
          if (&clr_row_q) begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end
        end else begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end

      ST_IDLE: begin
        if (bus.req_valid) begin
          mem_row   = req_row;
          mem_be    = bus.req_we ? phys_be(bus.req_be, req_off, 1'b1) : '0;
          mem_wdata = lane_to_phys(bus.req_wdata, req_off);
          if (req_off == '0) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = bus.req_we ? '0 : mem[req_row];
          end else begin
            // Low part handled now; remember the rest for the following row.
            state_d    = ST_SPLIT;
            hold_d     = mem[req_row];
            sp_row_d   = req_row + ROW_ONE;
            sp_off_d   = req_off;
            sp_we_d    = bus.req_we;
            sp_be_d    = bus.req_be;
            sp_wdata_d = bus.req_wdata;
          end
        end
      end

      ST_SPLIT: begin
        mem_row     = sp_row_q;
        mem_be      = sp_we_q ? phys_be(sp_be_q, sp_off_q, 1'b0) : '0;
        mem_wdata   = lane_to_phys(sp_wdata_q, sp_off_q);
        rsp_valid_d = 1'b1;
        rsp_rdata_d = sp_we_q ? '0 : phys_to_lane(hold_q, mem[sp_row_q], sp_off_q);
        state_d     = ST_IDLE;
      end

      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: the row array has no reset; zeroing is the INIT sweep's job, one row per cycle.
  always_ff @(posedge clk) begin
    for (int j = 0; j < BYTES; j++) begin
      if (mem_be[j]) mem[mem_row][8*j +: 8] <= mem_wdata[8*j +: 8];
    end
  end

  // NOTE: non-blocking updates so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      clr_row_q   <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      hold_q      <= '0;
      sp_row_q    <= '0;
      sp_off_q    <= '0;
      sp_we_q     <= 1'b0;
      sp_be_q     <= '0;
      sp_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_row_q   <= clr_row_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      hold_q      <= hold_d;
      sp_row_q    <= sp_row_d;
      sp_off_q    <= sp_off_d;
      sp_we_q     <= sp_we_d;
      sp_be_q     <= sp_be_d;
      sp_wdata_q  <= sp_wdata_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_sram_byte_ctrl.sv
// Drives an 8-bit-address and a 16-bit-address instance in lockstep and checks
// every response against byte-array reference models through per-instance scoreboards.
module tb_sram_byte_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = '0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  sram_byte_ctrl_if #(.ADDR_W(8),  .DATA_W(32)) b8 ();
  sram_byte_ctrl_if #(.ADDR_W(16), .DATA_W(32)) b16 ();

  assign b8.req_valid  = req_valid;
  assign b8.req_we     = req_we;
  assign b8.req_be     = req_be;
  assign b8.req_addr   = req_addr[7:0];
  assign b8.req_wdata  = req_wdata;
  assign b16.req_valid = req_valid;
  assign b16.req_we    = req_we;
  assign b16.req_be    = req_be;
  assign b16.req_addr  = req_addr;
  assign b16.req_wdata = req_wdata;

  sram_byte_ctrl #(.ADDR_W(8),  .DATA_W(32), .INIT_CLEAR(1'b1)) dut8  (.clk(clk), .rst(rst), .bus(b8));
  sram_byte_ctrl #(.ADDR_W(16), .DATA_W(32), .INIT_CLEAR(1'b1)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  // Reference memories: one byte per address, wrap by index width.
  logic [7:0] m8  [256];
  logic [7:0] m16 [65536];

  typedef struct {
    logic [31:0] data;
    longint      due;
  } exp_t;

  exp_t   q8[$];
  exp_t   q16[$];
  exp_t   e8, e16;
  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitors: pop one expectation per response pulse.
  always @(negedge clk) begin
    if (b8.rsp_valid) begin
      if (q8.size() == 0) check("rsp8_unexpected", {31'b0, b8.rsp_valid}, 32'd0);
      else begin
        e8 = q8.pop_front();
        check("rsp8_data", b8.rsp_rdata, e8.data);
        check("rsp8_latency", 32'(cyc), 32'(e8.due));
      end
    end
  end

  always @(negedge clk) begin
    if (b16.rsp_valid) begin
      if (q16.size() == 0) check("rsp16_unexpected", {31'b0, b16.rsp_valid}, 32'd0);
      else begin
        e16 = q16.pop_front();
        check("rsp16_data", b16.rsp_rdata, e16.data);
        check("rsp16_latency", 32'(cyc), 32'(e16.due));
      end
    end
  end

  // Called at a negedge; returns at a negedge with the request accepted.
  task automatic issue(input logic we, input logic [3:0] be, input logic [15:0] a,
                       input logic [31:0] wd);
    int   waited;
    bit   split;
    exp_t e;
    waited    = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_be    = be;
    req_addr  = a;
    req_wdata = wd;
    while (!(b8.req_ready && b16.req_ready) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!(b8.req_ready && b16.req_ready)) begin
      check("ready_timeout", {31'b0, b8.req_ready & b16.req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    split = (a[1:0] != 2'd0);
    e.due = cyc + 1 + (split ? 1 : 0);
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        logic [15:0] ak;
        ak = a + 16'(k);
        if (be[k]) begin
          m16[ak]     = wd[8*k +: 8];
          m8[ak[7:0]] = wd[8*k +: 8];
        end
      end
      e.data = '0;
      q8.push_back(e);
      q16.push_back(e);
    end else begin
      for (int k = 0; k < 4; k++) begin
        logic [15:0] ak;
        ak = a + 16'(k);
        e.data[8*k +: 8] = m16[ak];
      end
      q16.push_back(e);
      for (int k = 0; k < 4; k++) begin
        logic [15:0] ak;
        ak = a + 16'(k);
        e.data[8*k +: 8] = m8[ak[7:0]];
      end
      q8.push_back(e);
    end
    @(negedge clk);
    check("ready8_after_accept",  {31'b0, b8.req_ready},  {31'b0, !split});
    check("ready16_after_accept", {31'b0, b16.req_ready}, {31'b0, !split});
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    int n, n8;
    rst       = 1'b1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_init_done", {31'b0, b8.init_done}, 32'd0);
    check("rst_req_ready", {30'b0, b8.req_ready, b16.req_ready}, 32'd0);
    check("rst_rsp_valid", {30'b0, b8.rsp_valid, b16.rsp_valid}, 32'd0);
    check("rst_rsp_rdata8", b8.rsp_rdata, 32'd0);
    check("rst_rsp_rdata16", b16.rsp_rdata, 32'd0);
    for (int i = 0; i < 256; i++)   m8[i]  = 8'h00;
    for (int i = 0; i < 65536; i++) m16[i] = 8'h00;
    rst = 1'b0;
    n   = 0;
    n8  = 0;
    while (!b16.init_done && n < 17000) begin
      @(negedge clk);
      n++;
      if (b8.init_done && n8 == 0) n8 = n;
      if (!b16.init_done && b16.req_ready) check("ready16_during_init", 32'd1, 32'd0);
    end
    check("init8_cycles", 32'(n8), 32'd64);
    check("init16_cycles", 32'(n), 32'd16384);
  endtask

  task automatic drain(input string name);
    repeat (4) @(negedge clk);
    check({name, "_q8_empty"},  32'(q8.size()),  32'd0);
    check({name, "_q16_empty"}, 32'(q16.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Cleared contents, back-to-back aligned reads.
    for (int i = 0; i < 64; i++) issue(1'b0, 4'h0, 16'(i * 4), 32'h0);

    // Directed: full write, partial lanes, misaligned, no-op write, wrap.
    issue(1'b1, 4'hF, 16'h0010, 32'hDDCCBBAA);
    issue(1'b0, 4'h0, 16'h0010, 32'h0);
    issue(1'b1, 4'b0101, 16'h0010, 32'h11223344);
    issue(1'b0, 4'h0, 16'h0010, 32'h0);
    issue(1'b1, 4'hF, 16'h0013, 32'h44332211);
    issue(1'b0, 4'h0, 16'h0013, 32'h0);
    issue(1'b0, 4'h0, 16'h0010, 32'h0);
    issue(1'b1, 4'h0, 16'h0010, 32'hFFFFFFFF);
    issue(1'b0, 4'h0, 16'h0010, 32'h0);
    issue(1'b1, 4'hF, 16'hFFFE, 32'h87654321);
    issue(1'b0, 4'h0, 16'h0000, 32'h0);
    issue(1'b0, 4'h0, 16'hFFFC, 32'h0);
    drain("directed");

    // Random traffic concentrated near both ends of the address space.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      a = {($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00, 8'($urandom)};
      issue(1'($urandom), 4'($urandom), a, $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain("random");

    // Reset in the SPLIT cycle of a misaligned write: no response, clear restarts.
    issue(1'b1, 4'hF, 16'h0014, 32'hCAFEF00D);
    issue(1'b0, 4'h0, 16'h0014, 32'h0);
    drain("pre_abort");
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_be    = 4'hF;
    req_addr  = 16'h0013;
    req_wdata = 32'h5A5A5A5A;
    @(negedge clk);
    check("abort_in_split", {30'b0, b8.req_ready, b16.req_ready}, 32'd0);
    do_reset();
    issue(1'b0, 4'h0, 16'h0010, 32'h0);
    issue(1'b0, 4'h0, 16'h0014, 32'h0);
    issue(1'b0, 4'h0, 16'h0013, 32'h0);
    drain("post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
